// File: rtl/mult_hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply issue/retire stage.
package mult_hilo_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam int          MUL_LATENCY_DEF = 10;
    localparam logic [63:0] ZERO64          = 64'd0;

endpackage

// File: rtl/mult_hilo_unit_fix_adder.sv
// Unsigned correction for a signed 32x32 product: sum of the raw product and two shifted terms.
module hilo_fix_adder
    import mult_hilo_unit_pkg::*;
(
    input  logic [63:0] p_i,
    input  logic [63:0] corr_a_i,
    input  logic [63:0] corr_b_i,
    output logic [63:0] sum_o
);

    assign sum_o = p_i + corr_a_i + corr_b_i;

endmodule

// File: rtl/mult_hilo_unit.sv
// MULT/MULTU issue/retire around the Booth multiplier, plus the architectural HI/LO registers.
//  state   | meaning
//  ST_IDLE | no product in flight; HI/LO writable, Start accepted
//  ST_RUN  | multiplier working; counting its latency down to zero
//  ST_FIX  | product captured; apply unsigned correction and commit HI/LO
module mult_hilo_unit
    import mult_hilo_unit_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Signed_Op,
    input  logic [31:0] Rs_Val,
    input  logic [31:0] Rt_Val,
    input  logic        Mthi,
    input  logic        Mtlo,
    input  logic [31:0] Wr_Data,
    input  logic        Read_Req,
    output logic        Mul_Start,
    output logic [31:0] Mul_A,
    output logic [31:0] Mul_B,
    input  logic [63:0] Mul_Out,
    output logic        Busy,
    output logic        Done,
    output logic        Stall,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int            CW       = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LATENCY - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic          mul_start_q, mul_start_d;
    logic          done_q, done_d;
    logic [63:0]   prod_q, prod_d;
    logic          uflag_q, uflag_d;

    logic [63:0]   corr_a, corr_b, fixed_prod;
    logic          hilo_wr;

    // A signed product of operands with bit 31 set lacks 2^32*other for the unsigned reading.
    assign corr_a = (uflag_q && mul_a_q[31]) ? {mul_b_q, 32'd0} : ZERO64;
    assign corr_b = (uflag_q && mul_b_q[31]) ? {mul_a_q, 32'd0} : ZERO64;

    hilo_fix_adder u_fix_adder (
        .p_i      (prod_q),
        .corr_a_i (corr_a),
        .corr_b_i (corr_b),
        .sum_o    (fixed_prod)
    );

    assign hilo_wr = Mthi | Mtlo;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_start_d = 1'b0;
        done_d      = 1'b0;
        prod_d      = prod_q;
        uflag_d     = uflag_q;

        if (Mthi) hi_d = Wr_Data;
        if (Mtlo) lo_d = Wr_Data;

        unique case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    mul_a_d     = Rs_Val;
                    mul_b_d     = Rt_Val;
                    uflag_d     = ~Signed_Op;
                    mul_start_d = 1'b1;
                    count_d     = CNT_INIT;
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (hilo_wr) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (count_q == '0) begin
                    prod_d  = Mul_Out;
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_FIX: begin
                // A HI/LO write in the commit cycle still wins: the product is dropped.
                if (!hilo_wr) begin
                    hi_d   = fixed_prod[63:32];
                    lo_d   = fixed_prod[31:0];
                    done_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            done_q      <= 1'b0;
            prod_q      <= ZERO64;
            uflag_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_start_q <= mul_start_d;
            done_q      <= done_d;
            prod_q      <= prod_d;
            uflag_q     <= uflag_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Stall     = Read_Req & Busy;
    assign Done      = done_q;
    assign Mul_Start = mul_start_q;
    assign Mul_A     = mul_a_q;
    assign Mul_B     = mul_b_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed bench for mult_hilo_unit with a behavioural signed multiplier feeding Mul_Out.
module tb_mult_hilo_unit;

    localparam int L = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Signed_Op;
    logic [31:0] Rs_Val;
    logic [31:0] Rt_Val;
    logic        Mthi;
    logic        Mtlo;
    logic [31:0] Wr_Data;
    logic        Read_Req;
    logic        Mul_Start;
    logic [31:0] Mul_A;
    logic [31:0] Mul_B;
    logic [63:0] Mul_Out;
    logic        Busy;
    logic        Done;
    logic        Stall;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_tests = 0;
    int n_fail  = 0;

    mult_hilo_unit #(.MUL_LATENCY(L)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Signed_Op (Signed_Op),
        .Rs_Val    (Rs_Val),
        .Rt_Val    (Rt_Val),
        .Mthi      (Mthi),
        .Mtlo      (Mtlo),
        .Wr_Data   (Wr_Data),
        .Read_Req  (Read_Req),
        .Mul_Start (Mul_Start),
        .Mul_A     (Mul_A),
        .Mul_B     (Mul_B),
        .Mul_Out   (Mul_Out),
        .Busy      (Busy),
        .Done      (Done),
        .Stall     (Stall),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 Clk = ~Clk;

    // Signed multiplier model: product of the operand registers, valid for capture L cycles after launch.
    logic [63:0] prod_m;
    logic [63:0] pipe [0:L-2];
    assign prod_m  = {{32{Mul_A[31]}}, Mul_A} * {{32{Mul_B[31]}}, Mul_B};
    assign Mul_Out = pipe[L-2];
    always @(posedge Clk) begin
        pipe[0] <= prod_m;
        for (int k = 1; k <= L - 2; k++) pipe[k] <= pipe[k-1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic rd, input logic inj);
        @(negedge Clk);
        Start = 1'b1; Signed_Op = sgn; Rs_Val = a; Rt_Val = b; Read_Req = rd;
        @(negedge Clk);
        Start = 1'b0; Rs_Val = 32'h0BAD_0BAD; Rt_Val = 32'h0D0D_0D0D;
        #1;
        chk("mul_start_pulse", 64'(Mul_Start), 64'd1);
        chk("mul_a_latch", 64'(Mul_A), 64'(a));
        chk("mul_b_latch", 64'(Mul_B), 64'(b));
        chk("busy_after_start", 64'(Busy), 64'd1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (inj) begin
                Start  = (i == 3);
                Rs_Val = 32'd100;
                Rt_Val = 32'd100;
            end
            #1;
            chk("mul_start_low", 64'(Mul_Start), 64'd0);
            chk("done", 64'(Done), 64'(i == 11));
            chk("busy", 64'(Busy), 64'(i <= 10));
            if (rd) chk("stall", 64'(Stall), 64'(i <= 10));
            if (inj && i == 5) chk("mul_a_no_restart", 64'(Mul_A), 64'(a));
            if (i == 11) begin
                chk("hi_commit", 64'(Hi), 64'(eh));
                chk("lo_commit", 64'(Lo), 64'(el));
            end
        end
        Read_Req = 1'b0;
        Start    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Start = 1'b0; Signed_Op = 1'b0; Rs_Val = '0; Rt_Val = '0;
        Mthi = 1'b0; Mtlo = 1'b0; Wr_Data = '0; Read_Req = 1'b0;

        // Reset state
        repeat (2) @(negedge Clk);
        #1;
        chk("rst_hi", 64'(Hi), 64'd0);
        chk("rst_lo", 64'(Lo), 64'd0);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_done", 64'(Done), 64'd0);
        chk("rst_mul_start", 64'(Mul_Start), 64'd0);
        Reset = 1'b1;

        // Signed and unsigned products
        run_op(1'b1, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0);

        // Read_Req stalls while busy; Start mid-RUN ignored
        run_op(1'b1, 32'd5, 32'd5, 32'h0, 32'd25, 1'b1, 1'b1);

        // Mthi at count==4 aborts the operation
        @(negedge Clk);
        Start = 1'b1; Signed_Op = 1'b0; Rs_Val = 32'd2; Rt_Val = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        Mthi = 1'b1; Wr_Data = 32'h1234_5678;
        @(negedge Clk);
        Mthi = 1'b0; Wr_Data = '0;
        #1;
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_hi", 64'(Hi), 64'h1234_5678);
        chk("abort_lo", 64'(Lo), 64'd25);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            #1;
            chk("abort_no_done", 64'(Done), 64'd0);
        end
        chk("abort_hi_hold", 64'(Hi), 64'h1234_5678);
        chk("abort_lo_hold", 64'(Lo), 64'd25);

        // HI/LO write alongside Start: write lands, later commit overwrites both
        @(negedge Clk);
        Start = 1'b1; Signed_Op = 1'b1; Rs_Val = 32'd4; Rt_Val = 32'd5;
        Mthi = 1'b1; Mtlo = 1'b1; Wr_Data = 32'hDEAD_BEEF;
        @(negedge Clk);
        Start = 1'b0; Mthi = 1'b0; Mtlo = 1'b0; Wr_Data = '0;
        #1;
        chk("wr_start_hi", 64'(Hi), 64'hDEAD_BEEF);
        chk("wr_start_lo", 64'(Lo), 64'hDEAD_BEEF);
        chk("wr_start_busy", 64'(Busy), 64'd1);
        repeat (11) @(negedge Clk);
        #1;
        chk("wr_start_done", 64'(Done), 64'd1);
        chk("wr_start_hi_commit", 64'(Hi), 64'd0);
        chk("wr_start_lo_commit", 64'(Lo), 64'd20);

        // Plain MTHI/MTLO in idle
        @(negedge Clk);
        Mthi = 1'b1; Mtlo = 1'b1; Wr_Data = 32'hA5A5_A5A5;
        @(negedge Clk);
        Mthi = 1'b0; Wr_Data = 32'h0F0F_0F0F;
        #1;
        chk("mthilo_hi", 64'(Hi), 64'hA5A5_A5A5);
        chk("mthilo_lo", 64'(Lo), 64'hA5A5_A5A5);
        @(negedge Clk);
        Mtlo = 1'b0; Wr_Data = '0;
        #1;
        chk("mtlo_hi_hold", 64'(Hi), 64'hA5A5_A5A5);
        chk("mtlo_lo", 64'(Lo), 64'h0F0F_0F0F);

        // Reset mid-RUN discards the operation
        @(negedge Clk);
        Start = 1'b1; Signed_Op = 1'b1; Rs_Val = 32'd9; Rt_Val = 32'd9;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(Busy), 64'd0);
        chk("midrst_hi", 64'(Hi), 64'd0);
        chk("midrst_lo", 64'(Lo), 64'd0);
        chk("midrst_mul_a", 64'(Mul_A), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            #1;
            chk("midrst_no_done", 64'(Done), 64'd0);
        end
        run_op(1'b1, 32'd7, 32'd6, 32'h0, 32'h0000_002A, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
